// File: rtl/mult_pattern_arbiter_pkg.sv
// mpa_pkg: shared defaults, ID-width helper and pipeline record types for
// mult_pattern_arbiter. The record types reflect the default configuration;
// the top declares width-parameterised equivalents for its own stages.
package mpa_pkg;

  localparam int unsigned DEF_DW   = 8;
  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned DEF_CW   = 16;

  // Requester ID width; never narrower than one bit.
  function automatic int unsigned calc_idw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_IDW = calc_idw(DEF_NREQ);

  typedef struct packed {
    logic               vld;
    logic [DEF_IDW-1:0] id;
    logic [DEF_DW-1:0]  a;
    logic [DEF_DW-1:0]  b;
  } s1_t;

  typedef struct packed {
    logic                vld;
    logic [DEF_IDW-1:0]  id;
    logic [2*DEF_DW-1:0] prod;
    logic                hit;
  } out_t;

endpackage

// File: rtl/mult_pattern_arbiter_if.sv
// mpa_if: request and result handshake bundle for mult_pattern_arbiter.
//   req_valid/req_a/req_b/req_ready : per-requester request channel (packed,
//                                      requester i owns slice [i*DW +: DW])
//   out_valid/out_ready/out_prod/out_id/out_hit : result channel
// Modports: slave = arbiter side, master = requester/consumer side.
interface mpa_if
  import mpa_pkg::*;
#(
  parameter int unsigned DW   = DEF_DW,
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned IDW  = calc_idw(NREQ)
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid;
  logic               out_ready;
  logic [2*DW-1:0]    out_prod;
  logic [IDW-1:0]     out_id;
  logic               out_hit;

  modport slave (
    input  req_valid, req_a, req_b, out_ready,
    output req_ready, out_valid, out_prod, out_id, out_hit
  );

  modport master (
    output req_valid, req_a, req_b, out_ready,
    input  req_ready, out_valid, out_prod, out_id, out_hit
  );
endinterface

// File: rtl/mult_pattern_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   req    : request vector
//   en     : grant enable (no grant when low)
//   ptr    : last granted index; search starts at ptr+1 and wraps
//   gnt    : one-hot grant
//   gnt_id : encoded index of gnt (0 when nothing granted)
module rr_arbiter
  import mpa_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned IDW  = calc_idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic        found;
  int unsigned idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/mult_pattern_arbiter.sv
// mult_pattern_arbiter: round-robin shared DWxDW multiplier with pattern
// match. Two register stages (S1 operands, OUT result); one global enable
// stalls both stages when the result is held by the consumer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : mpa_if.slave request/result bundle
//   cfg_pattern : value compared against each product when OUT loads
//   hit_clr     : synchronous hit counter clear (MULT_PATTERN_HIT_COUNT_EN)
//   hit_cnt     : saturating hit counter (MULT_PATTERN_HIT_COUNT_EN)
module mult_pattern_arbiter
  import mpa_pkg::*;
#(
  parameter int unsigned DW   = DEF_DW,
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned IDW  = calc_idw(NREQ)
`ifdef MULT_PATTERN_HIT_COUNT_EN
  , parameter int unsigned CW = DEF_CW
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  mpa_if.slave            bus,
  input  logic [2*DW-1:0] cfg_pattern
`ifdef MULT_PATTERN_HIT_COUNT_EN
  , input  logic          hit_clr
  , output logic [CW-1:0] hit_cnt
`endif
);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
  } stage1_t;

  typedef struct packed {
    logic            vld;
    logic [IDW-1:0]  id;
    logic [2*DW-1:0] prod;
    logic            hit;
  } stage_out_t;

  stage1_t         s1;
  stage_out_t      out_q;
  logic [IDW-1:0]  rr_ptr;
  logic            adv;
  logic            xfer;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic [DW-1:0]   a_sel;
  logic [DW-1:0]   b_sel;
  logic [2*DW-1:0] prod_c;

  assign adv = !out_q.vld || bus.out_ready;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req    (bus.req_valid),
    .en     (adv),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // The arbiter only grants valid requesters, so any grant is a transfer.
  assign xfer          = |gnt;
  assign bus.req_ready = gnt;

  assign a_sel  = bus.req_a[32'(gnt_id)*DW +: DW];
  assign b_sel  = bus.req_b[32'(gnt_id)*DW +: DW];
  assign prod_c = (2*DW)'(s1.a) * (2*DW)'(s1.b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      out_q  <= '0;
      rr_ptr <= IDW'(NREQ - 1);
    end else if (adv) begin
      s1.vld     <= xfer;
      s1.id      <= gnt_id;
      s1.a       <= a_sel;
      s1.b       <= b_sel;
      out_q.vld  <= s1.vld;
      out_q.id   <= s1.id;
      out_q.prod <= prod_c;
      out_q.hit  <= (prod_c == cfg_pattern);
      if (xfer) rr_ptr <= gnt_id;
    end
  end

  assign bus.out_valid = out_q.vld;
  assign bus.out_prod  = out_q.prod;
  assign bus.out_id    = out_q.id;
  assign bus.out_hit   = out_q.hit;

`ifdef MULT_PATTERN_HIT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt <= '0;
    end else if (hit_clr) begin
      hit_cnt <= '0;
    end else if (out_q.vld && bus.out_ready && out_q.hit && (hit_cnt != '1)) begin
      hit_cnt <= hit_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mult_pattern_arbiter.sv
module tb_mult_pattern_arbiter;
  import mpa_pkg::*;

  localparam int unsigned DW   = 8;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = calc_idw(NREQ);
`ifdef MULT_PATTERN_HIT_COUNT_EN
  localparam int unsigned CW   = 2;
`endif

  typedef struct {
    int unsigned     id;
    logic [2*DW-1:0] prod;
    logic            hit;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2*DW-1:0] cfg_pattern = '0;
`ifdef MULT_PATTERN_HIT_COUNT_EN
  logic            hit_clr = 1'b0;
  logic [CW-1:0]   hit_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  exp_t            sb[$];
  int unsigned     grant_log[$];
  logic [2*DW-1:0] out_log[$];
  logic            last_hit = 1'b0;

  mpa_if #(.DW(DW), .NREQ(NREQ), .IDW(IDW)) bus ();

  mult_pattern_arbiter #(
    .DW   (DW),
    .NREQ (NREQ),
    .IDW  (IDW)
`ifdef MULT_PATTERN_HIT_COUNT_EN
    , .CW (CW)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .cfg_pattern (cfg_pattern)
`ifdef MULT_PATTERN_HIT_COUNT_EN
    , .hit_clr   (hit_clr)
    , .hit_cnt   (hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: push on request transfers, pop on result transfers.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          logic [DW-1:0] ea, eb;
          exp_t e;
          ea     = bus.req_a[i*DW +: DW];
          eb     = bus.req_b[i*DW +: DW];
          e.id   = i;
          e.prod = {{DW{1'b0}}, ea} * {{DW{1'b0}}, eb};
          e.hit  = (e.prod == cfg_pattern);
          sb.push_back(e);
          grant_log.push_back(i);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_prod", 32'(bus.out_prod), 32'(e.prod));
          check("out_id", 32'(bus.out_id), e.id);
          check("out_hit", 32'(bus.out_hit), 32'(e.hit));
        end
        out_log.push_back(bus.out_prod);
        last_hit = bus.out_hit;
      end
    end
  end

  task automatic send(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int   budget;
    logic got;
    budget = 0;
    got    = 1'b0;
    bus.req_a[i*DW +: DW] = a;
    bus.req_b[i*DW +: DW] = b;
    bus.req_valid[i] = 1'b1;
    do begin
      @(negedge clk);
      got = bus.req_ready[i];
      @(posedge clk); #1;
      budget++;
    end while (!got && budget < 100);
    bus.req_valid[i] = 1'b0;
    if (!got) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((sb.size() != 0 || bus.out_valid) && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 50) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.req_valid = '0;
    sb.delete();
    grant_log.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          exp_order[12];
    logic [2*DW-1:0] snap_prod;
    logic [IDW-1:0]  snap_id;

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #3;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_prod", 32'(bus.out_prod), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rel_out_valid", 32'(bus.out_valid), 32'd0);
    check("rel_out_id", 32'(bus.out_id), 32'd0);
    check("rel_out_hit", 32'(bus.out_hit), 32'd0);
`ifdef MULT_PATTERN_HIT_COUNT_EN
    check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
`endif

    // Single request and latency
    @(posedge clk); #1;
    cfg_pattern = 16'd18;
    bus.req_a[0 +: DW] = 8'd3;
    bus.req_b[0 +: DW] = 8'd6;
    bus.req_valid[0] = 1'b1;
    #1 check("single_ready", 32'(bus.req_ready), 32'b0001);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    check("lat_e_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_e1_valid", 32'(bus.out_valid), 32'd1);
    check("lat_e1_prod", 32'(bus.out_prod), 32'd18);
    check("lat_e1_id", 32'(bus.out_id), 32'd0);
    check("lat_e1_hit", 32'(bus.out_hit), 32'd1);
    drain();
    send(0, 8'd4, 8'd5);
    drain();
    check("single2_prod", 32'(out_log[$]), 32'd20);
    check("single2_hit", 32'(last_hit), 32'd0);

    // Boundary products
    cfg_pattern = 16'hFE01;
    send(0, 8'd255, 8'd255);
    drain();
    check("bnd_max_prod", 32'(out_log[$]), 32'hFE01);
    check("bnd_max_hit", 32'(last_hit), 32'd1);
    cfg_pattern = 16'd0;
    send(2, 8'd0, 8'd200);
    drain();
    check("bnd_zero_hit", 32'(last_hit), 32'd1);

    // Backpressure mid-stream on requester 1
    out_log.delete();
    fork
      begin
        for (int i = 1; i <= 6; i++) send(1, DW'(i), 8'd2);
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        snap_prod = bus.out_prod;
        snap_id   = bus.out_id;
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("stall_prod", 32'(bus.out_prod), 32'(snap_prod));
          check("stall_id", 32'(bus.out_id), 32'(snap_id));
          check("stall_ready", 32'(bus.req_ready), 32'd0);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 32'(out_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < out_log.size(); i++)
      check("bp_seq", 32'(out_log[i]), 32'(2 * (i + 1)));

    // Reset mid-operation with S1 and OUT both full
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.req_valid = '1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_prod", 32'(bus.out_prod), 32'd0);
    check("mid_rst_id", 32'(bus.out_id), 32'd0);
    check("mid_rst_hit", 32'(bus.out_hit), 32'd0);
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk); #1;
    bus.req_valid = '1;
    #1 check("post_rst_grant", 32'(bus.req_ready), 32'b0001);
    @(posedge clk); #1 bus.req_valid = '0;
    drain();

    // Round-robin order, then requester 2 drops out
    do_reset();
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 3, 0};
    cfg_pattern = 16'd100;
    for (int c = 0; c < 12; c++) begin
      for (int r = 0; r < int'(NREQ); r++) begin
        bus.req_a[r*DW +: DW] = DW'($urandom_range(0, 255));
        bus.req_b[r*DW +: DW] = DW'($urandom_range(0, 255));
      end
      bus.req_valid = (c < 8) ? 4'b1111 : 4'b1011;
      @(negedge clk);
      @(posedge clk); #1;
    end
    bus.req_valid = '0;
    drain();
    check("rr_count", 32'(grant_log.size()), 32'd12);
    for (int k = 0; k < 12 && k < grant_log.size(); k++)
      check("rr_grant", grant_log[k], 32'(exp_order[k]));

`ifdef MULT_PATTERN_HIT_COUNT_EN
    // Saturating hit counter with CW=2
    cfg_pattern = 16'd6;
    hit_clr = 1'b1;
    @(posedge clk); #1 hit_clr = 1'b0;
    check("hc_clr", 32'(hit_cnt), 32'd0);
    for (int i = 0; i < 5; i++) send(0, 8'd2, 8'd3);
    drain();
    check("hc_sat", 32'(hit_cnt), 32'd3);
    bus.out_ready = 1'b0;
    send(0, 8'd3, 8'd2);
    begin
      int budget;
      budget = 0;
      while (!bus.out_valid && budget < 20) begin
        @(posedge clk); #1;
        budget++;
      end
      check("hc_wait_valid", 32'(bus.out_valid), 32'd1);
    end
    hit_clr = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1 hit_clr = 1'b0;
    check("hc_clr_prio", 32'(hit_cnt), 32'd0);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_pattern_arbiter.md
Name: mult_pattern_arbiter

Overview:
- Shares one pipelined DW x DW multiplier with pattern detection among NREQ requesters.
- Requesters are selected round-robin; each result is returned with the requester ID and a hit flag.
- The hit flag is set when the product equals the runtime pattern.
- Sits between the requester agents and downstream result consumers; it is the only path into the multiplier.

Parameters:
- DW, 8, operand width; the product is 2*DW bits.
- NREQ, 4, number of requesters (2..16).
- IDW, $clog2(NREQ), requester ID width.
- CW, 16, hit counter width (HIT_COUNT_EN only).

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*DW  packed operand A; requester i owns bits [i*DW +: DW].
- req_b  in  NREQ*DW  packed operand B, same packing.
- req_ready  out  NREQ  one-hot grant; a transfer happens when valid[i] and ready[i] are both high.
- cfg_pattern  in  2*DW  pattern compared against each product.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_prod  out  2*DW  unsigned product a*b.
- out_id  out  IDW  index of the requester that issued the operands.
- out_hit  out  1  out_prod == cfg_pattern.
- hit_cnt  out  CW  saturating hit count (HIT_COUNT_EN only).
- hit_clr  in  1  synchronous clear of hit_cnt (HIT_COUNT_EN only).

Behaviour:
- Reset (async assert, sync release): out_valid, out_prod, out_id, out_hit, stage-1 valid and hit_cnt all 0; rr_ptr = NREQ-1, so requester 0 has first priority.
- Pipeline: S1 holds registered operands, id and valid. OUT holds the registered product, hit, id and valid. No combinational path from req_* to out_*.
- Global enable: adv = !out_valid || out_ready. When adv = 0, S1 and OUT hold and req_ready = 0.
- Grant: when adv = 1, req_ready is one-hot on the first requester with valid set, searching rr_ptr+1, rr_ptr+2, ... modulo NREQ. If no requester is valid, req_ready is all 0.
- req_ready is combinational from req_valid, rr_ptr and adv. A requester must not make valid depend on ready.
- rr_ptr updates to the granted index only on a transfer. Wrap: NREQ-1 -> 0.
- On adv, S1 loads the granted operands and id, with valid = transfer. OUT loads prod = S1.a*S1.b (full 2*DW, unsigned), hit = (prod == cfg_pattern) and valid = S1.valid.
- cfg_pattern is sampled on the edge that loads OUT. A pattern change affects only results loaded after that edge.
- Latency: transfer at edge E gives the result on out_* after edge E+1. Back-to-back throughput is 1 per cycle when out_ready is held high.
- Stall: out_valid high with out_ready low freezes out_* exactly, and S1 holds its contents. No result is dropped or duplicated.
- Simultaneous accept at the output and a new request in the same cycle is legal; full throughput is maintained.
- Reset mid-operation: in-flight S1/OUT contents are discarded; no out_valid follows reset release until a new transfer.
- A requester whose valid is high but not granted may change its operands freely; operands are sampled only on its transfer edge.
- Fairness: every continuously-valid requester is granted within NREQ transfers.

Optional Feature:
- Macro: MULT_PATTERN_HIT_COUNT_EN.
- Defined:
  - hit_cnt and hit_clr exist.
  - hit_cnt increments on each output transfer (out_valid && out_ready && out_hit) and saturates at all-ones.
  - hit_clr has priority: it zeroes the count even when an increment happens in the same cycle.
- Undefined: both ports and the counter logic are absent. All other behaviour is identical.

Decomposition:
- Package mpa_pkg holds:
  - default DW, NREQ and CW localparams;
  - the IDW function ($clog2 wrapper);
  - typedef s1_t {logic vld; logic [IDW-1:0] id; logic [DW-1:0] a, b};
  - typedef out_t {vld, id, prod, hit}.
- One sub-module: rr_arbiter (NREQ parameter). Inputs: req, en, ptr. Outputs: one-hot gnt, encoded gnt_id.
- Multiply/compare stays inline in mult_pattern_arbiter.

Test Plan (DW=8, NREQ=4):
- Single request: req0 a=3, b=6, cfg_pattern=18, out_ready=1 -> req_ready[0] on the same cycle; next edge+1: out_valid=1, out_prod=18, out_id=0, out_hit=1. Then a=4, b=5 -> out_prod=20, out_hit=0.
- Round-robin: all four valid continuously, out_ready=1 -> grant order 0,1,2,3,0,1..., out_id follows one cycle later. Drop req2 -> order 0,1,3,0.
- Backpressure: stream req1 a=i, b=2 for i=1..6 with out_ready low for 3 cycles mid-stream -> out_* frozen while stalled, req_ready=0, out_prod sequence exactly 2,4,6,8,10,12 with no loss.
- Boundary: a=255, b=255, cfg_pattern=16'hFE01 -> out_prod=16'hFE01, out_hit=1. a=0, b=200, cfg_pattern=0 -> out_hit=1.
- Reset: assert rst_n low while S1 and OUT are both valid -> outputs 0 immediately (async); after release, out_valid stays 0 until a new transfer; first grant goes to req0.
- MULT_PATTERN_HIT_COUNT_EN with CW=2: 5 hit transfers -> hit_cnt=3 (saturated). hit_clr and a hit transfer in the same cycle -> hit_cnt=0.
